// File: rtl/serial_adder_ctrl_pkg.sv
// Shared state encodings and sizing helpers for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam int unsigned MAX_WIDTH = 32;

  // The counter must be able to hold WIDTH itself, not just WIDTH-1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder cell, the only arithmetic in the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: operands are accepted once, then summed one bit per
// clock through a single full_adder cell, and the result is held until taken.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] sum_shifted;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             fa_s, fa_co;

  full_adder u_full_adder (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;

    // New sum bits enter at the MSB so the LSB-first result ends up aligned.
    sum_shifted            = sum_sh_q >> 1;
    sum_shifted[WIDTH-1]   = fa_s;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = sum_shifted;
        carry_d  = fa_co;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          sum_d   = sum_shifted;
          cout_d  = fa_co;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_HOLD);
    busy_d      = (state_d == ST_ADD) || (state_d == ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1, using a
// scoreboard of expected {cout,sum} values pushed on accept and popped on release.
module tb_serial_adder_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid, cin, out_ready, sel;
  logic [7:0] a, b;

  logic       iv8, iv1;
  logic       in_ready8, out_valid8, busy8, cout8;
  logic [7:0] sum8;
  logic       in_ready1, out_valid1, busy1, cout1;
  logic [0:0] sum1;

  logic       obs_in_ready, obs_out_valid, obs_busy, obs_cout;
  logic [7:0] obs_sum;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // sel picks which instance is exercised; the other one sees in_valid low.
  assign iv8 = in_valid & ~sel;
  assign iv1 = in_valid & sel;

  assign obs_in_ready  = sel ? in_ready1  : in_ready8;
  assign obs_out_valid = sel ? out_valid1 : out_valid8;
  assign obs_busy      = sel ? busy1      : busy8;
  assign obs_cout      = sel ? cout1      : cout8;
  assign obs_sum       = sel ? {7'b0, sum1} : sum8;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv8),
    .in_ready  (in_ready8),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .sum       (sum8),
    .cout      (cout8),
    .busy      (busy8)
  );

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv1),
    .in_ready  (in_ready1),
    .a         (a[0:0]),
    .b         (b[0:0]),
    .cin       (cin),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .sum       (sum1),
    .cout      (cout1),
    .busy      (busy1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One full transaction, called and returning at a negedge with the DUT idle.
  task automatic applyStimulus(input logic [7:0] op_a, input logic [7:0] op_b,
                               input logic op_cin, input int stall,
                               input logic iv_in_hold, input logic iv_on_release);
    int         w;
    int         n;
    int         acc;
    logic [7:0] m;
    logic [8:0] full;
    logic [8:0] exp9;
    w = sel ? 1 : 8;
    m = sel ? 8'h01 : 8'hFF;

    n = 0;
    while (!obs_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("in_ready", {31'b0, obs_in_ready}, 32'd1);

    a        = op_a;
    b        = op_b;
    cin      = op_cin;
    in_valid = 1'b1;
    full     = {1'b0, op_a & m} + {1'b0, op_b & m} + {8'b0, op_cin};
    exp9     = {full[w], full[7:0] & m};
    exp_q.push_back(exp9);
    acc      = cyc + 1;

    @(negedge clk);
    in_valid = 1'b0;
    a        = 8'($urandom);
    b        = 8'($urandom);
    cin      = 1'($urandom);
    checkOutput("accepted", {30'b0, obs_in_ready, obs_busy}, 32'd1);

    n = 0;
    while (!obs_out_valid && n < 40) begin
      out_ready = 1'($urandom);
      @(negedge clk);
      n++;
    end
    checkOutput("out_valid", {31'b0, obs_out_valid}, 32'd1);
    checkOutput("latency", cyc - acc, w);

    for (int i = 0; i < stall; i++) begin
      out_ready = 1'b0;
      in_valid  = iv_in_hold ? 1'($urandom) : 1'b0;
      @(negedge clk);
      checkOutput("hold_stable", {21'b0, obs_out_valid, obs_in_ready, obs_cout, obs_sum},
                  {21'b0, 2'b10, exp9});
    end

    out_ready = 1'b1;
    in_valid  = iv_on_release;
    checkOutput("result", {23'b0, obs_cout, obs_sum}, {23'b0, exp_q.pop_front()});

    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'($urandom);
    checkOutput("released", {29'b0, obs_out_valid, obs_in_ready, obs_busy}, 32'd2);
  endtask

  task automatic resetMidAdd(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_cin);
    a        = op_a;
    b        = op_b;
    cin      = op_cin;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("mid_add_busy", {31'b0, obs_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", {20'b0, obs_in_ready, obs_out_valid, obs_busy, obs_cout, obs_sum},
                32'h800);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("no_stale_result", {30'b0, obs_out_valid, obs_in_ready}, 32'd1);
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    cin       = 1'b0;
    out_ready = 1'b0;
    sel       = 1'b0;
    a         = 8'h00;
    b         = 8'h00;

    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_w8", {20'b0, in_ready8, out_valid8, busy8, cout8, sum8}, 32'h800);
    checkOutput("reset_w1", {27'b0, in_ready1, out_valid1, busy1, cout1, sum1}, 32'h10);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] WIDTH=8 directed cases");
    applyStimulus(8'h35, 8'h4A, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(8'hFF, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    applyStimulus(8'h12, 8'h34, 1'b1, 5, 1'b1, 1'b1);
    applyStimulus(8'hA5, 8'h5A, 1'b0, 2, 1'b0, 1'b0);
    resetMidAdd(8'hC3, 8'h3C, 1'b1);
    applyStimulus(8'h01, 8'h01, 1'b0, 0, 1'b0, 1'b0);

    $display("[TB] WIDTH=8 random back-to-back");
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3),
                    1'($urandom), 1'($urandom));
    end

    $display("[TB] WIDTH=1 cases");
    sel = 1'b1;
    @(negedge clk);
    applyStimulus(8'h01, 8'h01, 1'b1, 0, 1'b0, 1'b0);
    applyStimulus(8'h01, 8'h00, 1'b0, 3, 1'b1, 1'b1);
    for (int i = 0; i < 200; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 2),
                    1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
